peri_regbank_axil: RTL

- Parametrised AXI4-Lite slave register bank; successor to the fixed four-register constant peripheral.
- Provides NUM_RW software-writable control registers with byte strobes, plus NUM_RO hardware-driven status registers.
- Adds one-cycle write-commit pulses toward fabric logic and SLVERR on illegal accesses.
- Sits behind the PS/MicroBlaze AXI interconnect as a generic control/status peripheral for pitch-training IP.

---
 rtl/peri_regbank_axil_pkg.sv | 49 ++++
 rtl/peri_regbank_axil_if.sv | 36 +++
 rtl/peri_regbank_axil_wstrb_reg.sv | 48 ++++
 rtl/peri_regbank_axil.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peri_regbank_axil_pkg.sv
// Shared definitions for the peri_regbank_axil register bank: AXI response
// codes, channel state encodings and the word-index classifier.
package peri_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    typedef enum logic [1:0] {
        KIND_RW,
        KIND_RO,
        KIND_IRQ,
        KIND_INVALID
    } idx_kind_e;

    // Classify a word index: control block first, then status block, then the
    // two interrupt registers (only when the interrupt feature is built in).
    function automatic idx_kind_e idx_kind(input int idx, input int num_rw,
                                           input int num_ro, input logic irq_en);
        if (idx < num_rw) begin
            return KIND_RW;
        end else if (idx < num_rw + num_ro) begin
            return KIND_RO;
        end else if (irq_en && (idx < num_rw + num_ro + 2)) begin
            return KIND_IRQ;
        end
        return KIND_INVALID;
    endfunction

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/peri_regbank_axil_if.sv
// AXI4-Lite bus bundle for the register bank. The master modport is the
// interconnect side, the slave modport is the register bank side.
interface peri_regbank_axil_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/peri_regbank_axil_wstrb_reg.sv
// One software control register: byte-strobed update, programmable reset
// value, and a one-cycle pulse that coincides with the new value appearing.
module peri_regbank_wstrb_reg
    import peri_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic [DATA_WIDTH-1:0]   q_o,
    output logic                    pulse_o
);

    logic [DATA_WIDTH-1:0] val_q;
    logic [DATA_WIDTH-1:0] val_d;
    logic                  pulse_q;

    // Merge the strobed bytes of the write data over the current contents.
    always_comb begin
        val_d = val_q;
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb_i[b]) begin
                    val_d[b*8 +: 8] = wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Hold the register value and flag the cycle in which a write landed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q   <= RESET_VALUE;
            pulse_q <= 1'b0;
        end else begin
            val_q   <= val_d;
            pulse_q <= we_i;
        end
    end

    assign q_o     = val_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/peri_regbank_axil.sv
// AXI4-Lite control/status register bank: NUM_RW strobed control registers,
// NUM_RO hardware status registers, SLVERR on anything else. Defining
// PERI_REGBANK_IRQ_EN adds a sticky IRQ_STATUS / IRQ_ENABLE pair and a level
// interrupt output; without it those indices are invalid and irq is tied low.
module peri_regbank_axil
    import peri_regbank_pkg::*;
#(
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_RW     = 4,
    parameter int                             NUM_RO     = 4,
    parameter int                             ADDR_WIDTH = 7,
    parameter logic [NUM_RW*DATA_WIDTH-1:0]   RW_RESET   = '0
) (
    input  logic                                          s00_axi_aclk,
    input  logic                                          s00_axi_areset,
    peri_regbank_axil_if.slave                            s00_axi,
    output logic [NUM_RW*DATA_WIDTH-1:0]                  ctrl_q,
    output logic [NUM_RW-1:0]                             ctrl_wr_pulse,
    input  logic [(NUM_RO > 0 ? NUM_RO : 1)*DATA_WIDTH-1:0] status_d,
    input  logic [31:0]                                   irq_src,
    output logic                                          irq
);

    localparam int IDX_W          = ADDR_WIDTH - 2;
    localparam int IRQ_STATUS_IDX = NUM_RW + NUM_RO;

`ifdef PERI_REGBANK_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    wstate_e                 wstate_q, wstate_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    logic                    awready;
    logic                    wready;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    wr_commit;
    idx_kind_e               wr_kind;

    assign awready = !s00_axi_areset && !aw_held_q && !bvalid_q;
    assign wready  = !s00_axi_areset && !w_held_q && !bvalid_q;
    assign aw_hs   = s00_axi.awvalid && awready;
    assign w_hs    = s00_axi.wvalid && wready;
    assign wr_kind = idx_kind(32'(aw_idx_q), NUM_RW, NUM_RO, IRQ_EN);

    assign s00_axi.awready = awready;
    assign s00_axi.wready  = wready;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;

    // Capture AW and W independently, commit once both are held, then hold
    // the response until the master takes it.
    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_commit = 1'b0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi.awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi.wdata;
            wstrb_d  = s00_axi.wstrb;
        end

        case (wstate_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    wr_commit = 1'b1;
                    bvalid_d  = 1'b1;
                    bresp_d   = (wr_kind == KIND_RW || wr_kind == KIND_IRQ) ?
                                RESP_OKAY : RESP_SLVERR;
                    wstate_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi.bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    wstate_d  = W_IDLE;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // Write channel registers; reset drops any transaction in flight.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
        logic we;
        assign we = wr_commit && (wr_kind == KIND_RW) && (aw_idx_q == IDX_W'(i));

        peri_regbank_wstrb_reg #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RW_RESET[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_reg (
            .clk_i   (s00_axi_aclk),
            .rst_i   (s00_axi_areset),
            .we_i    (we),
            .wdata_i (wdata_q),
            .wstrb_i (wstrb_q),
            .q_o     (ctrl_q[i*DATA_WIDTH +: DATA_WIDTH]),
            .pulse_o (ctrl_wr_pulse[i])
        );
    end

    // ------------------------------------------------------------------
    // Interrupt registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] irq_status_rd;
    logic [DATA_WIDTH-1:0] irq_enable_rd;

`ifdef PERI_REGBANK_IRQ_EN
    logic [31:0] irq_status_q, irq_status_d;
    logic [31:0] irq_enable_q, irq_enable_d;
    logic        irq_q, irq_d;
    logic [31:0] wr_mask;

    assign wr_mask = strb_mask(wstrb_q);

    // Status bits are sticky and cleared by writing ones; a set pulse in the
    // same cycle as the clear keeps the bit, so no event is ever lost.
    always_comb begin
        irq_status_d = irq_status_q;
        irq_enable_d = irq_enable_q;
        if (wr_commit && wr_kind == KIND_IRQ) begin
            if (aw_idx_q == IDX_W'(IRQ_STATUS_IDX)) begin
                irq_status_d = irq_status_q & ~(wdata_q & wr_mask);
            end else begin
                irq_enable_d = (irq_enable_q & ~wr_mask) | (wdata_q & wr_mask);
            end
        end
        irq_status_d = irq_status_d | irq_src;
        irq_d        = |(irq_status_q & irq_enable_q);
    end

    // Interrupt registers and the registered level output.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            irq_status_q <= '0;
            irq_enable_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_enable_q <= irq_enable_d;
            irq_q        <= irq_d;
        end
    end

    assign irq           = irq_q;
    assign irq_status_rd = irq_status_q;
    assign irq_enable_rd = irq_enable_q;
`else
    logic unused_irq_src;
    assign unused_irq_src = ^irq_src;
    assign irq            = 1'b0;
    assign irq_status_rd  = '0;
    assign irq_enable_rd  = '0;
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_e               rstate_q, rstate_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  arready;
    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_idx;
    idx_kind_e             rd_kind;
    logic [DATA_WIDTH-1:0] rd_word;

    assign arready = !s00_axi_areset && !rvalid_q;
    assign ar_hs   = s00_axi.arvalid && arready;
    assign ar_idx  = s00_axi.araddr[ADDR_WIDTH-1:2];
    assign rd_kind = idx_kind(32'(ar_idx), NUM_RW, NUM_RO, IRQ_EN);

    assign s00_axi.arready = arready;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;

    // Select the word addressed by the read request; invalid indices read 0.
    always_comb begin
        rd_word = '0;
        case (rd_kind)
            KIND_RW: begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (ar_idx == IDX_W'(i)) begin
                        rd_word = ctrl_q[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            KIND_RO: begin
                for (int j = 0; j < NUM_RO; j++) begin
                    if (ar_idx == IDX_W'(NUM_RW + j)) begin
                        rd_word = status_d[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            KIND_IRQ: begin
                rd_word = (ar_idx == IDX_W'(IRQ_STATUS_IDX)) ? irq_status_rd : irq_enable_rd;
            end
            default: begin
                rd_word = '0;
            end
        endcase
    end

    // Register the read data on the address handshake and hold it until taken.
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d  = rd_word;
                    rresp_d  = (rd_kind == KIND_INVALID) ? RESP_SLVERR : RESP_OKAY;
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s00_axi.rready) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    // Read channel registers; reset drops any pending read data.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    // The two low address bits select bytes within a word and carry no meaning.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

endmodule
